// File: rtl/inst_fetch_if.sv
// Instruction-memory request port and decode handshake used by inst_fetch.
// master = fetch unit, slave = memory / decode / redirect environment.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              imem_en;
    logic [3:0]        imem_we;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] imem_adr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              fetch_err;

    modport master (
        output imem_en, imem_we, imem_wdata, imem_adr,
        output inst_valid, inst_data, inst_pc, fetch_err,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_en, imem_we, imem_wdata, imem_adr,
        input  inst_valid, inst_data, inst_pc, fetch_err,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads, buffers returned words in a
// small prefetch FIFO and presents them to decode; redirects flush everything in flight.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W     = 12
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OccW = CntW + 1;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            fetch_err_q, fetch_err_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [OccW-1:0] occupancy;

    assign pop = (count_q != '0) & bus.inst_ready;

    // Words already committed to the FIFO (buffered + returning) after this cycle's pop.
    assign occupancy = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);

    assign issue = rst_n & ~fetch_err_q & ~bus.redirect_valid
                 & (occupancy < OccW'(FIFO_DEPTH));

    // A returning word is squashed when a redirect lands in its arrival cycle.
    assign push = inflight_q & ~bus.redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fetch_err_d   = fetch_err_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d  = bus.redirect_pc;
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            fetch_err_d = |bus.redirect_pc[1:0];
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            fetch_err_q   <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_err_q   <= fetch_err_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data_q[wr_ptr_q] <= bus.imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign bus.imem_en    = issue;
    assign bus.imem_we    = 4'b0000;
    assign bus.imem_wdata = 32'h0;
    assign bus.imem_adr   = fetch_pc_q[ADDR_W+1:2];
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = fifo_data_q[rd_ptr_q];
    assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.fetch_err  = fetch_err_q;
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch initiator that drives the instruction memory port (EN / WE / adr / data_out, one-cycle registered read) and delivers instructions to decode through a valid/ready handshake. It holds the fetch PC and accounts for the one-cycle memory latency. A small prefetch FIFO sustains one instruction per cycle under back-pressure. A redirect input (branch/jump/trap target) flushes all in-flight and buffered words.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
FIFO_DEPTH, 2, prefetch buffer entries; power of two, >= 2
ADDR_W, 12, memory word-address width; imem_adr = fetch_pc[ADDR_W+1:2]

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
imem_en  output  1  memory access enable; a read is issued in every cycle this is 1
imem_we  output  4  byte write enables, tied 4'b0000
imem_wdata  output  32  write data, tied 32'h0
imem_adr  output  ADDR_W  word address of the current request
imem_rdata  input  32  read data, valid the cycle after an issued request
redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  input  32  redirect target byte address
inst_valid  output  1  inst_data/inst_pc hold a fetched instruction
inst_ready  input  1  decode accepts the instruction this cycle
inst_data  output  32  instruction word (FIFO head)
inst_pc  output  32  byte address of inst_data
fetch_err  output  1  sticky; set by a misaligned redirect

Behaviour:
- Reset: rst_n sampled 0 at a rising edge sets fetch_pc=RESET_PC, FIFO empty, inflight=0, fetch_err=0.
- While rst_n=0, imem_en is forced to 0 combinationally. inst_valid=0 and fetch_err=0 from the first edge that samples reset. inst_data/inst_pc are don't-care while inst_valid=0.
- Reset mid-operation discards everything, with no partial state retained.
- Issue rule: imem_en=1 when all of the following hold:
  - not halted;
  - redirect_valid=0;
  - (count + inflight − pop) < FIFO_DEPTH, where pop = inst_valid & inst_ready.
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32). With no issue, inflight<=0.
- Cycle after an issue: {imem_rdata, inflight_pc} is pushed into the FIFO at that cycle's edge, unless redirect_valid=1 in that cycle.
- Latency: issue in cycle N, imem_rdata valid in N+1, inst_valid=1 in N+2. There is no bypass path around the FIFO.
- Throughput: with inst_ready held 1 and FIFO_DEPTH>=2, one instruction per cycle in steady state.
- Handshake:
  - inst_valid, inst_data and inst_pc are driven from the FIFO head (registered state only).
  - Once inst_valid=1, the head stays stable until popped or flushed.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect, in the cycle redirect_valid=1:
  - FIFO flushed (count<=0); the in-flight word is squashed (not pushed); imem_en=0.
  - fetch_pc<=redirect_pc.
  - A handshake in the same cycle is void; the flush wins. Decode must treat that instruction as killed.
  - First issue at the target is in T+1; inst_valid=1 in T+3.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Flush as above; fetch_err<=1; fetch halts (imem_en=0, nothing issued).
  - Halt holds until reset or an aligned redirect, which clears fetch_err and resumes fetch at that target.
- Wrap-around: fetch_pc increments modulo 2^32. imem_adr aliases every 2^(ADDR_W+2) bytes. inst_pc always carries the full 32-bit PC.
- Writes: imem_we is never non-zero. This block never modifies memory.

Test Plan:
- Reset/stream:
  - Setup: memory word k = 32'h1000_0000+k, RESET_PC=0, inst_ready=1, rst_n released before cycle C0.
  - Expect imem_en=1 with adr=0 in C0.
  - Expect inst_valid=1 in C2 with data 32'h1000_0000, pc 0.
  - Then one instruction per cycle: pc 4, 8, 12 with data +1 each.
- Back-pressure: drop inst_ready for 6 cycles mid-stream -> outstanding words (FIFO + in-flight) never exceed 2; imem_en falls to 0; on release the sequence continues with no gap, duplicate or reorder.
- Redirect:
  - Drive redirect_pc=32'h100 in cycle T while the FIFO is full and inst_ready=1.
  - Expect imem_en=0 in T and adr=12'h040 in T+1.
  - Expect the next accepted instruction to be pc 32'h100 / mem[0x40] in T+3, with no pre-redirect word delivered after T.
- Misaligned redirect: redirect_pc=32'h102 -> fetch_err=1 from T+1; imem_en=0 and inst_valid=0 indefinitely. Then redirect_pc=32'h200 -> fetch_err=0; inst_pc 32'h200 appears 3 cycles later.
- Wrap: redirect_pc=32'hFFFF_FFFC -> imem_adr 12'hFFF then 12'h000; inst_pc 32'hFFFF_FFFC then 32'h0000_0000.
- Reset mid-operation: assert rst_n=0 for 1 cycle with the FIFO full and a read in flight -> inst_valid=0 and imem_en=0 during reset; after release, the first instruction delivered is at RESET_PC, with no stale data.
